traffic_light_ctrl: RTL and testbench



---
 rtl/traffic_light_ctrl_pkg.sv | 32 +++
 rtl/traffic_light_ctrl_if.sv | 30 +++
 rtl/traffic_light_ctrl_phase_timer.sv | 39 +++
 rtl/traffic_light_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_light_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// traffic_pkg
//   Shared definitions for the two-road intersection controller.
//   - Light encoding constants driven on ns_light / ew_light.
//   - 3-bit controller state enum; its code is also exported on `phase`.
//   - Helper deciding in which states a pedestrian request may be latched.
// ----------------------------------------------------------------------------
package traffic_pkg;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] GREEN  = 2'd1;
    localparam logic [1:0] YELLOW = 2'd2;
    localparam logic [1:0] OFF    = 2'd3;

    typedef enum logic [2:0] {
        NS_GRN = 3'd0,
        NS_YEL = 3'd1,
        CLR_A  = 3'd2,
        EW_GRN = 3'd3,
        EW_YEL = 3'd4,
        CLR_B  = 3'd5,
        PED    = 3'd6,
        FLASH  = 3'd7
    } state_e;

    // A button press is remembered everywhere except while it is being
    // served (PED) or while the intersection is in maintenance (FLASH).
    function automatic logic ped_can_latch(input state_e s);
        return (s != PED) && (s != FLASH);
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// ----------------------------------------------------------------------------
// traffic_light_ctrl_if
//   Groups the controller's functional signals.
//   Inputs to the controller : tick, ped_req, maint
//   Outputs of the controller: ns_light[1:0], ew_light[1:0], ped_walk,
//                              ped_pending, phase[2:0]
//   master = environment driving the controller, slave = the controller.
// ----------------------------------------------------------------------------
interface traffic_light_ctrl_if;

    logic       tick;
    logic       ped_req;
    logic       maint;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       ped_walk;
    logic       ped_pending;
    logic [2:0] phase;

    modport master (
        output tick, ped_req, maint,
        input  ns_light, ew_light, ped_walk, ped_pending, phase
    );

    modport slave (
        input  tick, ped_req, maint,
        output ns_light, ew_light, ped_walk, ped_pending, phase
    );

endinterface

// File: rtl/traffic_light_ctrl_phase_timer.sv
// ----------------------------------------------------------------------------
// phase_timer
//   Loadable down-counter timing one controller phase.
//   clk        : clock
//   load_i     : load load_val_i this cycle (wins over tick_i)
//   load_val_i : value to load (phase duration - 1)
//   tick_i     : advance strobe; decrements while count is nonzero
//   done_o     : count is zero and tick_i is high -> phase expires now
// The counter carries no reset of its own; the controller loads it on reset.
// ----------------------------------------------------------------------------
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             tick_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign done_o = tick_i && (cnt_q == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// ----------------------------------------------------------------------------
// traffic_light_ctrl
//   Two-road (NS/EW) intersection sequencer with all-red clearances, a
//   latched pedestrian walk phase and a maintenance flashing-yellow mode.
//   clk  : clock
//   rst  : synchronous, active-high reset (state CLR_B, timer CLR_CYC-1)
//   bus  : traffic_light_ctrl_if.slave
//            tick        phase-timer advance strobe
//            ped_req     pedestrian button (pulse or level)
//            maint       maintenance flash while high
//            ns_light    NS lamp (0 RED, 1 GREEN, 2 YELLOW, 3 OFF)
//            ew_light    EW lamp, same encoding
//            ped_walk    walk lamp, high only in PED
//            ped_pending request latched and not yet served
//            phase       current state code
//   All outputs decode from registered state only.
// ----------------------------------------------------------------------------
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int GREEN_CYC  = 10,
    parameter int YELLOW_CYC = 3,
    parameter int CLR_CYC    = 2,
    parameter int PED_CYC    = 6,
    parameter int FLASH_CYC  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_light_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LD    = CNT_W'(CLR_CYC - 1);
    localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_CYC - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_CYC - 1);

    // Timer preload for the state being entered.
    function automatic logic [CNT_W-1:0] load_for(input state_e s);
        logic [CNT_W-1:0] v;
        case (s)
            NS_GRN, EW_GRN: v = GREEN_LD;
            NS_YEL, EW_YEL: v = YELLOW_LD;
            CLR_A, CLR_B:   v = CLR_LD;
            PED:            v = PED_LD;
            FLASH:          v = FLASH_LD;
            default:        v = CLR_LD;
        endcase
        return v;
    endfunction

    state_e           state_q, state_d;
    logic             pend_q, pend_d;
    logic             next_ew_q, next_ew_d;   // PED exits to EW_GRN when set
    logic             flash_off_q, flash_off_d;
    logic             flash_flip;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_done;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .tick_i     (bus.tick),
        .done_o     (tmr_done)
    );

    // Next-state, pending latch and timer control.
    always_comb begin
        state_d     = state_q;
        next_ew_d   = next_ew_q;
        flash_off_d = flash_off_q;
        pend_d      = pend_q;
        flash_flip  = 1'b0;

        if (bus.maint) begin
            // Maintenance overrides the sequence immediately, tick or not.
            state_d = FLASH;
            if ((state_q == FLASH) && tmr_done) begin
                flash_flip  = 1'b1;
                flash_off_d = ~flash_off_q;
            end
        end else begin
            case (state_q)
                NS_GRN: if (tmr_done) state_d = NS_YEL;
                NS_YEL: if (tmr_done) state_d = CLR_A;
                CLR_A: begin
                    if (tmr_done) begin
                        if (pend_q) begin
                            state_d   = PED;
                            next_ew_d = 1'b1;
                        end else begin
                            state_d = EW_GRN;
                        end
                    end
                end
                EW_GRN: if (tmr_done) state_d = EW_YEL;
                EW_YEL: if (tmr_done) state_d = CLR_B;
                CLR_B: begin
                    if (tmr_done) begin
                        if (pend_q) begin
                            state_d   = PED;
                            next_ew_d = 1'b0;
                        end else begin
                            state_d = NS_GRN;
                        end
                    end
                end
                PED: if (tmr_done) state_d = next_ew_q ? EW_GRN : NS_GRN;
                // maint just fell: leave through a clearance interval.
                FLASH:   state_d = CLR_B;
                default: state_d = CLR_B;
            endcase
        end

        // Flash always restarts on the YELLOW half.
        if (state_d != FLASH) begin
            flash_off_d = 1'b0;
        end

        // Entering PED consumes the request; a press on that same cycle
        // is part of the request being served and is dropped.
        if (bus.maint) begin
            pend_d = 1'b0;
        end else if ((state_d == PED) && (state_q != PED)) begin
            pend_d = 1'b0;
        end else if (bus.ped_req && ped_can_latch(state_q)) begin
            pend_d = 1'b1;
        end

        tmr_load = rst || (state_d != state_q) || flash_flip;
        if (rst) begin
            tmr_load_val = CLR_LD;
        end else if (flash_flip) begin
            tmr_load_val = FLASH_LD;
        end else begin
            tmr_load_val = load_for(state_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLR_B;
            pend_q      <= 1'b0;
            next_ew_q   <= 1'b0;
            flash_off_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            next_ew_q   <= next_ew_d;
            flash_off_q <= flash_off_d;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        bus.ns_light = RED;
        bus.ew_light = RED;
        case (state_q)
            NS_GRN: bus.ns_light = GREEN;
            NS_YEL: bus.ns_light = YELLOW;
            EW_GRN: bus.ew_light = GREEN;
            EW_YEL: bus.ew_light = YELLOW;
            FLASH: begin
                bus.ns_light = flash_off_q ? OFF : YELLOW;
                bus.ew_light = flash_off_q ? OFF : YELLOW;
            end
            default: begin
                bus.ns_light = RED;
                bus.ew_light = RED;
            end
        endcase
        bus.ped_walk    = (state_q == PED);
        bus.ped_pending = pend_q;
        bus.phase       = state_q;
    end

    // Conflicting greens/yellows are only tolerated in maintenance flash.
    a_no_conflict : assert property (
        @(posedge clk) disable iff (rst)
        (state_q != FLASH) |-> ((bus.ns_light == RED) || (bus.ew_light == RED))
    );

endmodule

// File: tb/tb_traffic_light_ctrl.sv
module tb_traffic_light_ctrl;
    import traffic_pkg::*;

    localparam int CNT_W      = 8;
    localparam int GREEN_CYC  = 10;
    localparam int YELLOW_CYC = 3;
    localparam int CLR_CYC    = 2;
    localparam int PED_CYC    = 6;
    localparam int FLASH_CYC  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    traffic_light_ctrl_if bus ();

    traffic_light_ctrl #(
        .CNT_W      (CNT_W),
        .GREEN_CYC  (GREEN_CYC),
        .YELLOW_CYC (YELLOW_CYC),
        .CLR_CYC    (CLR_CYC),
        .PED_CYC    (PED_CYC),
        .FLASH_CYC  (FLASH_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [8:0] exp_q[$];

    // Reference model: counts elapsed ticks in the current phase.
    int m_st = 5;
    int m_el = 0;
    bit m_pend = 0;
    bit m_next_ew = 0;
    bit m_fo = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int dur(input int s);
        case (s)
            0, 3:    return GREEN_CYC;
            1, 4:    return YELLOW_CYC;
            6:       return PED_CYC;
            7:       return FLASH_CYC;
            default: return CLR_CYC;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit t, input bit p, input bit m);
        int  st0   = m_st;
        bit  pend0 = m_pend;
        if (r) begin
            m_st = 5; m_el = 0; m_pend = 0; m_next_ew = 0; m_fo = 0;
            return;
        end
        if (m) begin
            if (st0 != 7) begin
                m_st = 7; m_el = 0; m_fo = 0;
            end else if (t) begin
                m_el++;
                if (m_el == FLASH_CYC) begin
                    m_el = 0; m_fo = !m_fo;
                end
            end
            m_pend = 0;
        end else if (st0 == 7) begin
            m_st = 5; m_el = 0; m_fo = 0;
        end else begin
            if (t) begin
                m_el++;
                if (m_el == dur(st0)) begin
                    m_el = 0;
                    case (st0)
                        0: m_st = 1;
                        1: m_st = 2;
                        2: if (pend0) begin m_st = 6; m_next_ew = 1; end else m_st = 3;
                        3: m_st = 4;
                        4: m_st = 5;
                        5: if (pend0) begin m_st = 6; m_next_ew = 0; end else m_st = 0;
                        6: m_st = m_next_ew ? 3 : 0;
                        default: m_st = 5;
                    endcase
                end
            end
            if (m_st == 6 && st0 != 6) m_pend = 0;
            else if (p && st0 != 6) m_pend = 1;
        end
    endtask

    function automatic logic [8:0] model_out();
        logic [1:0] ns = 2'd0;
        logic [1:0] ew = 2'd0;
        case (m_st)
            0: ns = 2'd1;
            1: ns = 2'd2;
            3: ew = 2'd1;
            4: ew = 2'd2;
            7: begin ns = m_fo ? 2'd3 : 2'd2; ew = ns; end
            default: ;
        endcase
        return {ns, ew, (m_st == 6), m_pend, 3'(m_st)};
    endfunction

    function automatic logic [8:0] dut_out();
        return {bus.ns_light, bus.ew_light, bus.ped_walk, bus.ped_pending, bus.phase};
    endfunction

    // One clock: drive, predict, clock, compare against the scoreboard.
    task automatic step(input bit r, input bit t, input bit p, input bit m);
        logic [8:0] e;
        rst         = r;
        bus.tick    = t;
        bus.ped_req = p;
        bus.maint   = m;
        model_step(r, t, p, m);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        if (r) cyc = 0; else cyc++;
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("sb_out", 32'(dut_out()), 32'(e));
        end
    endtask

    task automatic do_reset();
        step(1, 1, 0, 0);
        step(1, 0, 1, 1);
        check_eq("rst_out", 32'(dut_out()), 32'h005);
    endtask

    // Directed checkpoints of the plain 30-cycle sequence after reset.
    task automatic seq_checks(input string pfx);
        case (cyc)
            1:  check_eq({pfx, "_clr_b_1"},  32'(bus.phase),    32'd5);
            2:  check_eq({pfx, "_ns_grn_2"}, 32'(bus.ns_light), 32'd1);
            11: check_eq({pfx, "_ns_grn_11"}, 32'(bus.ns_light), 32'd1);
            12: check_eq({pfx, "_ns_yel_12"}, 32'(bus.ns_light), 32'd2);
            15: check_eq({pfx, "_clr_a_15"}, 32'(bus.phase),    32'd2);
            17: check_eq({pfx, "_ew_grn_17"}, 32'(bus.ew_light), 32'd1);
            27: check_eq({pfx, "_ew_yel_27"}, 32'(bus.ew_light), 32'd2);
            30: check_eq({pfx, "_clr_b_30"}, 32'(bus.phase),    32'd5);
            32: check_eq({pfx, "_ns_grn_32"}, 32'(bus.ns_light), 32'd1);
            default: ;
        endcase
    endtask

    initial begin
        bus.tick = 1'b0; bus.ped_req = 1'b0; bus.maint = 1'b0;
        @(negedge clk);

        // Free-running sequence.
        do_reset();
        while (cyc < 34) begin
            step(0, 1, 0, 0);
            seq_checks("s1");
        end

        // Single pedestrian pulse.
        do_reset();
        while (cyc < 30) begin
            step(0, 1, (cyc == 5), 0);
            case (cyc)
                6:  check_eq("s2_pend_set", 32'(bus.ped_pending), 32'd1);
                17: begin
                    check_eq("s2_ped_phase", 32'(bus.phase), 32'd6);
                    check_eq("s2_walk", 32'(bus.ped_walk), 32'd1);
                    check_eq("s2_pend_clr", 32'(bus.ped_pending), 32'd0);
                end
                22: check_eq("s2_ped_last", 32'(bus.phase), 32'd6);
                23: check_eq("s2_ew_after", 32'(bus.ew_light), 32'd1);
                default: ;
            endcase
        end

        // Slow tick: one tick every 4 clocks.
        do_reset();
        while (cyc < 140) begin
            step(0, (cyc % 4 == 0), 0, 0);
            if (cyc == 4)  check_eq("s3_clr_hold", 32'(bus.phase), 32'd5);
            if (cyc == 5)  check_eq("s3_ns_start", 32'(bus.phase), 32'd0);
            if (cyc == 44) check_eq("s3_ns_end",   32'(bus.phase), 32'd0);
            if (cyc == 45) check_eq("s3_yel",      32'(bus.phase), 32'd1);
        end

        // Maintenance flash entered mid EW green with a request pending.
        do_reset();
        while (cyc < 40) begin
            step(0, 1, (cyc == 18), (cyc >= 20 && cyc <= 31));
            case (cyc)
                19: check_eq("s4_pend_set", 32'(bus.ped_pending), 32'd1);
                21: begin
                    check_eq("s4_flash", 32'(bus.phase), 32'd7);
                    check_eq("s4_yel", 32'(bus.ns_light), 32'd2);
                    check_eq("s4_pend_clr", 32'(bus.ped_pending), 32'd0);
                end
                25: check_eq("s4_off", 32'(bus.ew_light), 32'd3);
                29: check_eq("s4_yel2", 32'(bus.ns_light), 32'd2);
                33: check_eq("s4_clr_b", 32'(bus.phase), 32'd5);
                35: check_eq("s4_ns_grn", 32'(bus.ns_light), 32'd1);
                default: ;
            endcase
        end

        // Reset mid NS yellow with a request pending; rst beats maint/ped_req.
        do_reset();
        while (cyc < 13) step(0, 1, (cyc == 5), 0);
        check_eq("s5_pre_phase", 32'(bus.phase), 32'd1);
        check_eq("s5_pre_pend", 32'(bus.ped_pending), 32'd1);
        step(1, 1, 1, 1);
        check_eq("s5_rst_out", 32'(dut_out()), 32'h005);
        while (cyc < 34) begin
            step(0, 1, 0, 0);
            seq_checks("s5");
        end

        // Button held through the walk phase.
        do_reset();
        while (cyc < 42) begin
            step(0, 1, (cyc >= 10 && cyc <= 30), 0);
            case (cyc)
                17: check_eq("s6_ped", 32'(bus.phase), 32'd6);
                22: check_eq("s6_pend_ign", 32'(bus.ped_pending), 32'd0);
                23: check_eq("s6_no_rewalk", 32'(bus.ped_walk), 32'd0);
                24: check_eq("s6_relatch", 32'(bus.ped_pending), 32'd1);
                37: check_eq("s6_clr_b", 32'(bus.phase), 32'd5);
                38: check_eq("s6_ped2", 32'(bus.phase), 32'd6);
                default: ;
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
